stab_col_reduce: RTL and testbench

- Sequential stabilizer-frame reducer that stores `num_qubit` Pauli rows (literals plus sign phase).
- On command, eliminates the X-component of one qubit column from all rows except one pivot, using Pauli row multiplication.
- Sits upstream of, and embeds, the frame's row-product logic.
- Used between gate application and measurement-outcome extraction in the Heisenberg emulator.

---
 rtl/stab_col_reduce.sv | 177 +++++++++++++++++
 tb/tb_stab_col_reduce.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stab_col_reduce.sv
// Stabilizer-frame column reducer: stores num_qubit Pauli rows and clears the
// X component of one qubit column from every row except the first row holding it.
module stab_col_reduce #(
  parameter int num_qubit = 4,
  parameter int idx_w     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic [idx_w-1:0]       load_idx,
  input  logic [2*num_qubit-1:0] load_literals,
  input  logic                   load_phase,
  input  logic                   start,
  input  logic [idx_w-1:0]       col_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   pivot_found,
  output logic [idx_w-1:0]       pivot_idx,
  input  logic [idx_w-1:0]       rd_idx,
  output logic [2*num_qubit-1:0] rd_literals,
  output logic                   rd_phase
);
  localparam int LW = 2 * num_qubit;
  localparam logic [idx_w:0] NQ_EXT = (idx_w + 1)'(num_qubit);
  localparam logic [idx_w-1:0] LAST_ROW = idx_w'(num_qubit - 1);

  typedef enum logic [1:0] {IDLE, SCAN, MULT, DONE} state_t;

  state_t                state_q, state_d;
  logic [idx_w-1:0]      r_q, r_d;
  logic [idx_w-1:0]      col_q, col_d;
  logic [idx_w-1:0]      pivot_idx_q, pivot_idx_d;
  logic                  pivot_found_q, pivot_found_d;
  logic [LW-1:0]         lit_q [num_qubit];
  logic [num_qubit-1:0]  phase_q;

  logic [LW-1:0]         cur_lit, piv_lit, prod_lit;
  logic                  cur_phase, piv_phase, prod_phase;
  logic [num_qubit-1:0]  col_hit_v;
  logic [num_qubit-1:0][1:0] fac;
  logic [1:0]            fsum;
  logic                  hit, last, load_en, mult_wr;

  // Phase power of i contributed by one qubit of target x pivot.
  function automatic logic [1:0] qubit_factor(input logic [1:0] t, input logic [1:0] v);
    logic [1:0] f;
    case ({t, v})
      4'b10_11, 4'b11_01, 4'b01_10: f = 2'd1;
      4'b10_01, 4'b11_10, 4'b01_11: f = 2'd3;
      default:                      f = 2'd0;
    endcase
    return f;
  endfunction

  // Row muxes written as compare loops so out-of-range indices read as zero.
  always_comb begin
    cur_lit     = '0;
    cur_phase   = 1'b0;
    piv_lit     = '0;
    piv_phase   = 1'b0;
    rd_literals = '0;
    rd_phase    = 1'b0;
    for (int k = 0; k < num_qubit; k++) begin
      if (r_q == idx_w'(k)) begin
        cur_lit   = lit_q[k];
        cur_phase = phase_q[k];
      end
      if (pivot_idx_q == idx_w'(k)) begin
        piv_lit   = lit_q[k];
        piv_phase = phase_q[k];
      end
      if (rd_idx == idx_w'(k)) begin
        rd_literals = lit_q[k];
        rd_phase    = phase_q[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < num_qubit; gi++) begin : g_qubit
      assign col_hit_v[gi] = cur_lit[2*gi+1] & (col_q == idx_w'(gi));
      assign fac[gi]       = qubit_factor(cur_lit[2*gi+1:2*gi], piv_lit[2*gi+1:2*gi]);
    end
  endgenerate

  always_comb begin
    fsum = 2'd0;
    for (int k = 0; k < num_qubit; k++) begin
      fsum = fsum + fac[k];
    end
  end

  assign prod_lit   = cur_lit ^ piv_lit;
  assign prod_phase = cur_phase ^ piv_phase ^ (fsum == 2'd2);
  assign hit        = |col_hit_v;
  assign last       = (r_q == LAST_ROW);
  assign load_en    = (state_q == IDLE) && load_valid && ({1'b0, load_idx} < NQ_EXT);

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    col_d         = col_q;
    pivot_idx_d   = pivot_idx_q;
    pivot_found_d = pivot_found_q;
    mult_wr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pivot_found_d = 1'b0;
          pivot_idx_d   = '0;
          col_d         = col_sel;
          r_d           = '0;
          state_d       = ({1'b0, col_sel} < NQ_EXT) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (hit) begin
          pivot_idx_d   = r_q;
          pivot_found_d = 1'b1;
          r_d           = '0;
          state_d       = MULT;
        end else if (last) begin
          state_d = DONE;
        end else begin
          r_d = r_q + idx_w'(1);
        end
      end
      MULT: begin
        mult_wr = hit && (r_q != pivot_idx_q);
        if (last) state_d = DONE;
        else      r_d = r_q + idx_w'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      r_q           <= '0;
      col_q         <= '0;
      pivot_idx_q   <= '0;
      pivot_found_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      col_q         <= col_d;
      pivot_idx_q   <= pivot_idx_d;
      pivot_found_q <= pivot_found_d;
    end
  end

  // Loads and products never coincide: loads happen only in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < num_qubit; k++) lit_q[k] <= '0;
      phase_q <= '0;
    end else begin
      for (int k = 0; k < num_qubit; k++) begin
        if (load_en && load_idx == idx_w'(k)) begin
          lit_q[k]   <= load_literals;
          phase_q[k] <= load_phase;
        end else if (mult_wr && r_q == idx_w'(k)) begin
          lit_q[k]   <= prod_lit;
          phase_q[k] <= prod_phase;
        end
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign pivot_found = pivot_found_q;
  assign pivot_idx   = pivot_idx_q;

endmodule

// File: tb/tb_stab_col_reduce.sv
// Randomized self-checking bench for stab_col_reduce against a Pauli-algebra model.
module tb_stab_col_reduce;
  localparam int NQ = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [7:0]    load_literals = '0;
  logic          load_phase = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] col_sel = '0;
  logic          busy, done, pivot_found;
  logic [IW-1:0] pivot_idx;
  logic [IW-1:0] rd_idx = '0;
  logic [7:0]    rd_literals;
  logic          rd_phase;

  stab_col_reduce #(.num_qubit(NQ), .idx_w(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_idx(load_idx),
    .load_literals(load_literals), .load_phase(load_phase),
    .start(start), .col_sel(col_sel),
    .busy(busy), .done(done), .pivot_found(pivot_found), .pivot_idx(pivot_idx),
    .rd_idx(rd_idx), .rd_literals(rd_literals), .rd_phase(rd_phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: Pauli letter per qubit (0=I,1=Z,2=X,3=Y) and sign per row.
  int m_p [NQ][NQ];
  bit m_s [NQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int ord(input int p);
    case (p)
      2: return 0;
      3: return 1;
      default: return 2;
    endcase
  endfunction

  // Power of i in a*b for single-qubit Paulis: cyclic X->Y->Z gives +i.
  function automatic int ipow(input int a, input int b);
    if (a == 0 || b == 0 || a == b) return 0;
    return (((ord(b) - ord(a) + 3) % 3) == 1) ? 1 : 3;
  endfunction

  function automatic bit has_x(input int p);
    return (p == 2 || p == 3);
  endfunction

  function automatic logic [7:0] pack_row(input int r);
    logic [7:0] v;
    v = '0;
    for (int q = 0; q < NQ; q++) v[2*q +: 2] = 2'(m_p[r][q]);
    return v;
  endfunction

  task automatic model_set(input int idx, input logic [7:0] lit, input logic ph);
    for (int q = 0; q < NQ; q++) m_p[idx][q] = int'(lit[2*q +: 2]);
    m_s[idx] = ph;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NQ; r++) model_set(r, 8'h00, 1'b0);
  endtask

  task automatic model_reduce(input int col, output bit found, output int piv);
    int pw;
    found = 0;
    piv   = 0;
    if (col < NQ) begin
      for (int r = NQ - 1; r >= 0; r--) if (has_x(m_p[r][col])) begin found = 1; piv = r; end
    end
    if (found) begin
      for (int r = 0; r < NQ; r++) begin
        if (r != piv && has_x(m_p[r][col])) begin
          pw = 0;
          for (int q = 0; q < NQ; q++) begin
            pw += ipow(m_p[r][q], m_p[piv][q]);
            m_p[r][q] = m_p[r][q] ^ m_p[piv][q];
          end
          m_s[r] = m_s[r] ^ m_s[piv] ^ ((pw % 4) == 2);
        end
      end
    end
  endtask

  task automatic drive_load(input int idx, input logic [7:0] lit, input logic ph);
    @(negedge clk);
    load_valid = 1'b1; load_idx = IW'(idx); load_literals = lit; load_phase = ph;
    @(posedge clk); #1;
    load_valid = 1'b0;
    if (idx < NQ) model_set(idx, lit, ph);
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < NQ; r++) begin
      rd_idx = IW'(r);
      #1;
      check($sformatf("%s row%0d lit", tag, r), 32'(rd_literals), 32'(pack_row(r)));
      check($sformatf("%s row%0d phase", tag, r), 32'(rd_phase), 32'(m_s[r]));
    end
  endtask

  task automatic run_reduce(input string tag, input int col, input bit with_load,
                            input int lidx, input logic [7:0] llit, input logic lph,
                            input bit inject);
    int cnt;
    bit found;
    int piv;
    int exp_lat;
    @(negedge clk);
    start = 1'b1; col_sel = IW'(col);
    if (with_load) begin
      load_valid = 1'b1; load_idx = IW'(lidx); load_literals = llit; load_phase = lph;
    end
    @(posedge clk); #1;
    start = 1'b0; load_valid = 1'b0;
    if (with_load && lidx < NQ) model_set(lidx, llit, lph);
    model_reduce(col, found, piv);
    exp_lat = found ? (piv + 1 + NQ + 1) : ((col < NQ) ? NQ + 1 : 1);
    check({tag, " busy"}, 32'(busy), 32'd1);
    cnt = 1;
    while (done !== 1'b1 && cnt < 60) begin
      if (inject && cnt == 1) begin
        start = 1'b1; col_sel = '0;
        load_valid = 1'b1; load_idx = '0; load_literals = 8'hFF; load_phase = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; load_valid = 1'b0;
      cnt++;
    end
    check({tag, " latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, " pivot_found"}, 32'(pivot_found), 32'(found));
    check({tag, " pivot_idx"}, 32'(pivot_idx), found ? 32'(piv) : 32'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " pivot held"}, 32'(pivot_found), 32'(found));
    check_rows(tag);
    $display("txn %s col=%0d found=%0d piv=%0d latency=%0d", tag, col, found, piv, cnt);
  endtask

  initial begin
    rst_n = 1'b1;
    model_clear();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pivot_found", 32'(pivot_found), 32'd0);
    check("reset pivot_idx", 32'(pivot_idx), 32'd0);
    check_rows("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed pivot case with sign toggle on row 2.
    drive_load(0, 8'h01, 1'b0);
    drive_load(1, 8'h0A, 1'b0);
    drive_load(2, 8'h0F, 1'b0);
    drive_load(3, 8'h00, 1'b0);
    run_reduce("pivot", 0, 0, 0, 8'h00, 1'b0, 0);
    rd_idx = 3'd2; #1;
    check("pivot r2 literals const", 32'(rd_literals), 32'h05);
    check("pivot r2 phase const", 32'(rd_phase), 32'd1);
    check("pivot idx const", 32'(pivot_idx), 32'd1);

    // No pivot anywhere.
    for (int r = 0; r < NQ; r++) drive_load(r, 8'h55, 1'b0);
    run_reduce("nopivot", 2, 0, 0, 8'h00, 1'b0, 0);

    // Out-of-range column and readout index; out-of-range load is dropped.
    run_reduce("oor col", 4, 0, 0, 8'h00, 1'b0, 0);
    drive_load(5, 8'hAA, 1'b1);
    rd_idx = 3'd5; #1;
    check("oor rd literals", 32'(rd_literals), 32'd0);
    check("oor rd phase", 32'(rd_phase), 32'd0);
    check_rows("oor load");

    // Start and load while busy must be ignored.
    drive_load(0, 8'h08, 1'b0);
    drive_load(1, 8'h02, 1'b1);
    run_reduce("ignored", 0, 0, 0, 8'h00, 1'b0, 1);

    // Randomized rows, columns, and simultaneous load+start.
    for (int it = 0; it < 16; it++) begin
      for (int r = 0; r < NQ; r++) drive_load(r, 8'($urandom), 1'($urandom));
      run_reduce($sformatf("rand%0d", it), int'($urandom_range(0, 4)), (it % 3) == 0,
                 int'($urandom_range(0, 5)), 8'($urandom), 1'($urandom), 0);
    end

    // Reset during MULT aborts immediately.
    drive_load(0, 8'h02, 1'b0);
    drive_load(1, 8'h03, 1'b1);
    drive_load(2, 8'h0A, 1'b0);
    drive_load(3, 8'h06, 1'b0);
    @(negedge clk);
    start = 1'b1; col_sel = '0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check_rows("midreset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("midreset no done", 32'(done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int r = 0; r < NQ; r++) drive_load(r, 8'($urandom), 1'($urandom));
    drive_load(1, 8'h2E, 1'b0);
    run_reduce("after reset", 1, 0, 0, 8'h00, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
